next_pc_sequencer: RTL and testbench

NEXT_PC_SEQUENCER -- requirements
Module: next_pc_sequencer

---
 rtl/next_pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_next_pc_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_sequencer.sv
// ---------------------------------------------------------------------------
// next_pc_sequencer
//
// Fetch/execute sequencer for a single-issue MIPS-style core. Walks a
// three-state loop (IDLE -> FETCH -> EXEC -> FETCH ...), requests the
// instruction at PC, latches it into IR, then computes the following PC from
// the jr / jump / branch / sequential controls presented during EXEC.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   Instruction  imem read data, taken only in FETCH with ImemReady=1
//   RsData       register rs value, the jr target
//   Branch       branch condition true       (EXEC, Stall=0 only)
//   Jump         j/jal decode                (EXEC, Stall=0 only)
//   JumpReg      jr decode                   (EXEC, Stall=0 only)
//   Stall        freeze the instruction in EXEC
//   ImemReady    imem has data for the requested PC
//   PC           current fetch/execute address (registered)
//   ImemReq      fetch request for PC (high in FETCH)
//   IR           latched instruction (registered)
//   InstrValid   IR holds the instruction at PC (high in EXEC)
//   AddrErr      single-cycle pulse when a jr target is not word aligned
// ---------------------------------------------------------------------------
module next_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic [31:0] RsData,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        Stall,
    input  logic        ImemReady,
    output logic [31:0] PC,
    output logic        ImemReq,
    output logic [31:0] IR,
    output logic        InstrValid,
    output logic        AddrErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        ir_load;
    logic        pc_load;

    logic [31:0] pc_seq;
    logic [31:0] br_off;
    logic [31:0] pc_br;
    logic [31:0] pc_j;
    logic [31:0] pc_jr;
    logic [31:0] pc_nxt;
    logic        jr_misaligned;

    // -----------------------------------------------------------------------
    // Candidate targets. All additions are 32-bit and wrap naturally.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_seq        = PC + 32'd4;
        br_off        = {{14{IR[15]}}, IR[15:0], 2'b00};
        pc_br         = pc_seq + br_off;
        pc_j          = {PC[31:28], IR[25:0], 2'b00};
        // Low bits are forced to zero; misalignment is flagged, not trapped.
        pc_jr         = {RsData[31:2], 2'b00};
        jr_misaligned = |RsData[1:0];
    end

    // Priority: jr, then jump, then branch, then fall-through.
    always_comb begin
        pc_nxt = pc_seq;
        if (JumpReg)
            pc_nxt = pc_jr;
        else if (Jump)
            pc_nxt = pc_j;
        else if (Branch)
            pc_nxt = pc_br;
    end

    // -----------------------------------------------------------------------
    // FSM next-state and outputs. ImemReq/InstrValid/AddrErr decode straight
    // from state, so an asynchronous reset clears them without a clock.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        AddrErr    = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                ImemReq = 1'b1;
                if (ImemReady) begin
                    ir_load   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                InstrValid = 1'b1;
                if (!Stall) begin
                    pc_load   = 1'b1;
                    state_nxt = FETCH;
                    // Only the advancing cycle reports the bad jr target.
                    AddrErr   = JumpReg & jr_misaligned;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC <= RESET_PC;
            IR <= 32'h0000_0000;
        end else begin
            if (ir_load)
                IR <= Instruction;
            if (pc_load)
                PC <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_next_pc_sequencer.sv
module tb_next_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction;
    logic [31:0] RsData;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic        Stall;
    logic        ImemReady;
    logic [31:0] PC;
    logic        ImemReq;
    logic [31:0] IR;
    logic        InstrValid;
    logic        AddrErr;

    next_pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .Instruction (Instruction),
        .RsData      (RsData),
        .Branch      (Branch),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .Stall       (Stall),
        .ImemReady   (ImemReady),
        .PC          (PC),
        .ImemReq     (ImemReq),
        .IR          (IR),
        .InstrValid  (InstrValid),
        .AddrErr     (AddrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_ir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    // Precondition: at posedge+1 with the DUT in FETCH.
    task automatic do_fetch(input logic [31:0] instr, input int waits);
        ImemReady   = 1'b0;
        Instruction = 32'hDEAD_BEEF;
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            chk("wait_req", {31'd0, ImemReq}, 32'd1);
            chk("wait_pc", PC, model_pc);
            chk("wait_iv", {31'd0, InstrValid}, 32'd0);
        end
        ImemReady   = 1'b1;
        Instruction = instr;
        exp_q.push_back(instr);
        @(posedge clk); #1;
        ImemReady   = 1'b0;
        Instruction = ~instr;
        model_ir    = instr;
        sb_pop("ir_load", IR);
        chk("exec_iv", {31'd0, InstrValid}, 32'd1);
        chk("exec_req", {31'd0, ImemReq}, 32'd0);
        chk("exec_pc", PC, model_pc);
    endtask

    // Precondition: at posedge+1 with the DUT in EXEC.
    task automatic do_exec(input int stalls, input logic br, input logic j,
                           input logic jr, input logic [31:0] rs);
        logic [31:0] nxt;
        logic        aerr;
        for (int i = 0; i < stalls; i++) begin
            Stall = 1'b1; Branch = 1'b1; Jump = 1'b1; JumpReg = 1'b1;
            RsData = 32'h0000_0003;
            #1 chk("stall_aerr", {31'd0, AddrErr}, 32'd0);
            @(posedge clk); #1;
            chk("stall_pc", PC, model_pc);
            chk("stall_ir", IR, model_ir);
            chk("stall_iv", {31'd0, InstrValid}, 32'd1);
        end
        Stall = 1'b0; Branch = br; Jump = j; JumpReg = jr; RsData = rs;
        if (jr)
            nxt = rs & 32'hFFFF_FFFC;
        else if (j)
            nxt = {model_pc[31:28], model_ir[25:0], 2'b00};
        else if (br)
            nxt = model_pc + 32'd4 + 32'($signed(model_ir[15:0])) * 32'd4;
        else
            nxt = model_pc + 32'd4;
        aerr = jr && (rs[1:0] != 2'b00);
        exp_q.push_back(nxt);
        #1 chk("aerr", {31'd0, AddrErr}, {31'd0, aerr});
        @(posedge clk); #1;
        Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0; RsData = 32'h0;
        sb_pop("next_pc", PC);
        chk("adv_req", {31'd0, ImemReq}, 32'd1);
        chk("adv_iv", {31'd0, InstrValid}, 32'd0);
        chk("aerr_clr", {31'd0, AddrErr}, 32'd0);
        model_pc = nxt;
    endtask

    // Called with rst high at posedge+1; releases and checks the IDLE cycle.
    task automatic release_reset();
        rst = 1'b0;
        exp_q.delete();
        model_pc = RESET_PC;
        model_ir = 32'h0;
        chk("idle_req", {31'd0, ImemReq}, 32'd0);
        @(posedge clk); #1;
        chk("first_req", {31'd0, ImemReq}, 32'd1);
        chk("first_pc", PC, RESET_PC);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, PC, RESET_PC);
        chk({tag, "_ir"}, IR, 32'h0);
        chk({tag, "_req"}, {31'd0, ImemReq}, 32'd0);
        chk({tag, "_iv"}, {31'd0, InstrValid}, 32'd0);
        chk({tag, "_aerr"}, {31'd0, AddrErr}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; Instruction = 32'h0; RsData = 32'h0;
        Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0; Stall = 1'b0; ImemReady = 1'b0;
        model_pc = RESET_PC; model_ir = 32'h0;

        // Power-on reset
        #2 rst = 1'b1;
        #1 chk_reset_state("por");
        @(posedge clk); #1;
        release_reset();

        // Sequential flow 0 -> 4 -> 8
        do_fetch(32'h2000_0001, 0);
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq_pc4", PC, 32'h4);
        do_fetch(32'h2000_0002, 0);
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq_pc8", PC, 32'h8);

        // Wait states
        do_fetch(32'h1234_5678, 3);
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Branch backwards from 0x100
        do_fetch(32'h0000_0000, 0);
        do_exec(0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        do_fetch(32'h1000_FFFE, 1);
        do_exec(0, 1'b1, 1'b0, 1'b0, 32'h0000_0003);
        chk("branch_pc", PC, 32'h0000_00FC);

        // Jump keeps the PC region bits
        do_fetch(32'h0000_0000, 0);
        do_exec(0, 1'b0, 1'b0, 1'b1, 32'hA000_0010);
        do_fetch(32'h0800_0040, 0);
        do_exec(0, 1'b1, 1'b1, 1'b0, 32'h0000_0003);
        chk("jump_pc", PC, 32'hA000_0100);

        // Priority with misaligned jr target
        do_fetch(32'h0BFF_FFFE, 0);
        do_exec(0, 1'b1, 1'b1, 1'b1, 32'h0000_2003);
        chk("prio_pc", PC, 32'h0000_2000);

        // Stall then wrap
        do_fetch(32'h0000_0000, 0);
        do_exec(0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        do_fetch(32'h1000_0005, 0);
        do_exec(4, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc", PC, 32'h0000_0000);

        // Async reset between edges while in FETCH
        do_fetch(32'h2000_0003, 0);
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);
        ImemReady = 1'b1; Instruction = 32'h5555_AAAA;
        #3 rst = 1'b1;
        #1 chk_reset_state("rst_fetch");
        ImemReady = 1'b0;
        @(posedge clk); #1;
        chk_reset_state("rst_fetch_hold");
        release_reset();

        // Async reset while stalled in EXEC
        do_fetch(32'h0000_0000, 0);
        do_exec(0, 1'b0, 1'b0, 1'b1, 32'h0000_4440);
        do_fetch(32'h1000_0010, 0);
        Stall = 1'b1; Branch = 1'b1;
        #3 rst = 1'b1;
        #1 chk_reset_state("rst_stall");
        Stall = 1'b0; Branch = 1'b0;
        @(posedge clk); #1;
        release_reset();
        do_fetch(32'h2000_0004, 0);
        do_exec(0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_rst_pc", PC, RESET_PC + 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
